uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver_pkg.sv | 36 +++
 rtl/uart_rx_fifo.sv | 52 +++++
 rtl/uart_receiver.sv | 162 ++++++++++++++++
 tb/tb_uart_receiver.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, register
// offsets and STATUS word layout.
package uart_receiver_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } rx_state_e;

    localparam logic RegData   = 1'b0;
    localparam logic RegStatus = 1'b1;

    localparam int unsigned StatEmptyBit    = 0;
    localparam int unsigned StatFullBit     = 1;
    localparam int unsigned StatFrameErrBit = 2;
    localparam int unsigned StatOverrunBit  = 3;
    localparam int unsigned StatCountLsb    = 8;

    function automatic logic [31:0] status_word(input logic [7:0] count,
                                                input logic       overrun,
                                                input logic       frame_err,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] w;
        w                      = '0;
        w[StatCountLsb +: 8]   = count;
        w[StatOverrunBit]      = overrun;
        w[StatFrameErrBit]     = frame_err;
        w[StatFullBit]         = full;
        w[StatEmptyBit]        = empty;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters; pointers carry one extra wrap bit so
// full and empty are distinguished by comparing the MSBs.
module uart_rx_fifo #(
    parameter  int unsigned Depth = 8,
    localparam int unsigned AW    = $clog2(Depth),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [Depth];
    logic [CW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] rptr_q, rptr_d;
    logic          do_push, do_pop;

    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        count   = wptr_q - rptr_q;
        rdata   = mem_q[rptr_q[AW-1:0]];
        do_pop  = pop && !empty;
        // A pop in the same cycle frees the slot the push lands in.
        do_push = push && (!full || do_pop);
        wptr_d  = wptr_q + CW'(do_push);
        rptr_d  = rptr_q + CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling, receive FIFO and a two-register
// read interface (DATA pops a byte, STATUS reports and clears sticky errors).
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 24_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uart_rx,
    input  logic        rden,
    input  logic        addr,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int unsigned DIV  = CLOCK_RATE / BAUD_RATE;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CntW = $clog2(DIV);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CntW-1:0] DivM1  = CntW'(DIV - 1);
    localparam logic [CntW-1:0] HalfM1 = CntW'(HALF - 1);

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            irq_q, irq_d;

    logic            push, pop, frame_evt, overrun_evt, stat_clr;
    logic [7:0]      fifo_rdata;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [7:0]      count8;

    assign rdata = rdata_q;
    assign irq   = irq_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Only a fresh falling edge starts a frame, so a held break
                // cannot retrigger.
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = StStart;
                    cnt_d   = HalfM1;
                end
            end
            StStart: begin
                if (cnt_q == '0) begin
                    if (!rx_sync_q) begin
                        state_d = StData;
                        cnt_d   = DivM1;
                        idx_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rx_sync_q;
                    cnt_d          = DivM1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == '0) begin
                    push      = rx_sync_q;
                    frame_evt = !rx_sync_q;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count8      = 8'(fifo_count);
        pop         = rden && (addr == RegData) && !fifo_empty;
        stat_clr    = rden && (addr == RegStatus);
        overrun_evt = push && fifo_full && !pop;
        rdata_d     = rdata_q;
        if (rden) begin
            if (addr == RegData) begin
                rdata_d = fifo_empty ? 32'h0 : {23'b0, 1'b1, fifo_rdata};
            end else begin
                rdata_d = status_word(count8, overrun_q, frame_err_q, fifo_full, fifo_empty);
            end
        end
        // Set beats clear when both happen in the same cycle.
        overrun_d   = overrun_evt || (overrun_q && !stat_clr);
        frame_err_d = frame_evt || (frame_err_q && !stat_clr);
        irq_d       = !fifo_empty;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            rx_meta_q   <= uart_rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    uart_rx_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .wdata (shift_q),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: reads queue their expected word, and a
// monitor compares each registered read result as it appears.
module tb_uart_receiver;

    localparam int unsigned Div  = 208;
    localparam int unsigned Half = 104;

    logic        clk     = 1'b0;
    logic        rstn    = 1'b0;
    logic        uart_rx = 1'b1;
    logic        rden    = 1'b0;
    logic        addr    = 1'b0;
    logic [31:0] rdata;
    logic        irq;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned nread  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic        rd_pend = 1'b0;

    always #5 clk = ~clk;

    uart_receiver #(
        .CLOCK_RATE (24_000_000),
        .BAUD_RATE  (115200),
        .FIFO_DEPTH (8)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .uart_rx (uart_rx),
        .rden    (rden),
        .addr    (addr),
        .rdata   (rdata),
        .irq     (irq)
    );

    always @(posedge clk) rd_pend <= rden;

    always @(negedge clk) begin
        if (rd_pend) begin
            nread++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read#%0d unexpected read, got %h", nread, rdata);
            end else begin
                exp_v = exp_q.pop_front();
                if (rdata !== exp_v) begin
                    errors++;
                    $display("FAIL read#%0d got %h expected %h", nread, rdata, exp_v);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Called on a falling edge; the strobe is sampled on the next rising edge.
    task automatic read_reg(input logic a, input logic [31:0] exp);
        addr = a;
        rden = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        rden = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the line at the stop-bit level so a break can be extended.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        idle(Div);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(Div);
        end
        uart_rx = stop;
        idle(Div);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        rstn = 1'b1;
        idle(5);
        read_reg(1'b1, 32'h0000_0001);

        // Single byte then read past empty.
        send_frame(8'hA5, 1'b1);
        idle(4);
        check("irq_after_rx", {31'b0, irq}, 32'h1);
        read_reg(1'b0, 32'h0000_01A5);
        read_reg(1'b0, 32'h0000_0000);
        idle(2);
        check("irq_after_drain", {31'b0, irq}, 32'h0);
        read_reg(1'b1, 32'h0000_0001);

        // Nine bytes into an eight-deep FIFO.
        for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b1);
        idle(4);
        read_reg(1'b1, 32'h0000_080A);
        for (int b = 1; b <= 8; b++) read_reg(1'b0, 32'h0000_0100 | 32'(b));
        read_reg(1'b1, 32'h0000_0001);

        // Half-bit glitch on an idle line.
        uart_rx = 1'b0;
        idle(Half);
        uart_rx = 1'b1;
        idle(2 * Div);
        read_reg(1'b1, 32'h0000_0001);

        // Bad stop bit followed by a long break, then a good frame.
        send_frame(8'h55, 1'b0);
        read_reg(1'b1, 32'h0000_0005);
        idle(20 * Div);
        uart_rx = 1'b1;
        idle(2 * Div);
        read_reg(1'b1, 32'h0000_0001);
        send_frame(8'h3C, 1'b1);
        idle(4);
        read_reg(1'b0, 32'h0000_013C);
        read_reg(1'b1, 32'h0000_0001);

        // Full FIFO with a DATA read landing on the stop-bit push edge:
        // push happens 3 + Half + 9*Div rising edges after the start bit.
        for (int b = 8'h11; b <= 8'h18; b++) send_frame(8'(b), 1'b1);
        idle(4);
        read_reg(1'b1, 32'h0000_0802);
        fork
            send_frame(8'h19, 1'b1);
            begin
                idle(3 + Half + 9 * Div - 1);
                read_reg(1'b0, 32'h0000_0111);
            end
        join
        idle(4);
        read_reg(1'b1, 32'h0000_0802);
        for (int b = 8'h12; b <= 8'h19; b++) read_reg(1'b0, 32'h0000_0100 | 32'(b));
        read_reg(1'b1, 32'h0000_0001);

        // Reset in the middle of data bit 4.
        send_frame(8'hA2, 1'b1);
        idle(4);
        read_reg(1'b1, 32'h0000_0100);
        check("irq_before_reset", {31'b0, irq}, 32'h1);
        fork
            send_frame(8'h7E, 1'b1);
            begin
                idle(5 * Div + 100);
                rstn = 1'b0;
                #1;
                check("midframe_reset_rdata", rdata, 32'h0);
                check("midframe_reset_irq", {31'b0, irq}, 32'h0);
            end
        join
        idle(10);
        rstn = 1'b1;
        idle(Div);
        read_reg(1'b1, 32'h0000_0001);
        send_frame(8'h7E, 1'b1);
        idle(4);
        read_reg(1'b0, 32'h0000_017E);
        read_reg(1'b1, 32'h0000_0001);

        idle(4);
        check("pending_expectations", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
